stack_lifo: RTL and testbench

Hardware LIFO serving as the operand stack of the multicycle stack processor. It sits directly beside the processor core: it accepts `push`/`pop` strobes and write data from the core, and continuously presents the current top of stack back to it. It reports `full`/`empty` and an occupancy count. Optional sticky error flags record illegal push/pop attempts.

---
 rtl/stack_pkg.sv | 30 +++
 rtl/stack_mem.sv | 29 ++
 rtl/stack_lifo.sv | 138 +++++++++++++
 tb/tb_stack_lifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the operand-stack LIFO.
//   WIDTH_DEF / DEPTH_DEF : default data width and entry count
//   ptr_width()           : width needed to hold an occupancy of 0..DEPTH
//   op_t / decode_op()    : per-edge operation decoded from {push, pop}
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic op_t decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: single-write-port, single-read-port register array.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// Contents are intentionally not reset.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo.sv
// stack_lifo: operand stack for the multicycle stack processor.
//   clk, reset       : clock and asynchronous active-high reset
//   push, pop        : operation strobes sampled on the rising edge
//   data_in          : word to push (or to replace the top with)
//   data_out         : registered top of stack, 0 when empty
//   full/empty/count : decoded from the registered stack pointer
// Optional (macro STACK_ERR_FLAGS_EN):
//   err_clear                    : clears the sticky error flags
//   overflow_err / underflow_err : sticky illegal push / pop flags
module stack_lifo
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
`ifdef STACK_ERR_FLAGS_EN
  input  logic                       err_clear,
  output logic                       overflow_err,
  output logic                       underflow_err,
`endif
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  op_t              op;
  logic [PW-1:0]    sp;
  logic [WIDTH-1:0] top;
  logic             is_empty;
  logic             is_full;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  assign op       = decode_op(push, pop);
  assign is_empty = (sp == '0);
  assign is_full  = (sp == PW'(DEPTH));

  // Look-ahead read of the entry beneath the top, so a pop can load it into
  // the top register on the same edge. Modular wrap is harmless: the value
  // is only used when sp >= 2.
  assign mem_raddr = sp[AW-1:0] - AW'(2);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp[AW-1:0];
    case (op)
      OP_PUSH: mem_we = !is_full;
      OP_REPLACE: begin
        mem_we = 1'b1;
        // On an empty stack a replace degenerates into a plain push at slot 0.
        if (!is_empty) mem_waddr = sp[AW-1:0] - AW'(1);
      end
      default: mem_we = 1'b0;
    endcase
  end

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(data_in),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      top <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (!is_full) begin
            sp  <= sp + PW'(1);
            top <= data_in;
          end
        end
        OP_POP: begin
          if (sp > PW'(1)) begin
            sp  <= sp - PW'(1);
            top <= mem_rdata;
          end else if (!is_empty) begin
            sp  <= '0;
            top <= '0;
          end
        end
        OP_REPLACE: begin
          top <= data_in;
          if (is_empty) sp <= PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_out = top;
  assign full     = is_full;
  assign empty    = is_empty;
  assign count    = sp;

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = (op == OP_PUSH) && is_full;
  assign unf_set = ((op == OP_POP) || (op == OP_REPLACE)) && is_empty;

  // A new error on the same edge as err_clear wins: the set is applied last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (err_clear) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end
      if (ovf_set) overflow_err  <= 1'b1;
      if (unf_set) underflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_lifo.sv
module tb_stack_lifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
`ifdef STACK_ERR_FLAGS_EN
  logic          err_clear;
  logic          overflow_err;
  logic          underflow_err;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: a queue whose last element is the top of stack.
  logic [W-1:0] mq[$];
  bit           m_ovf;
  bit           m_unf;

  always #5 clk = ~clk;

  stack_lifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
`ifdef STACK_ERR_FLAGS_EN
    .err_clear    (err_clear),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
`endif
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  function automatic logic [W-1:0] m_top();
    if (mq.size() == 0) return '0;
    return mq[mq.size()-1];
  endfunction

  task automatic m_update(input logic p, input logic q, input logic [W-1:0] d, input logic clr);
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (p && !q) begin
      if (mq.size() < D) mq.push_back(d);
      else m_ovf = 1;
    end else if (!p && q) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else m_unf = 1;
    end else if (p && q) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else begin
        mq.push_back(d);
        m_unf = 1;
      end
    end
  endtask

  // One clock edge of stimulus; outputs are settled 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [W-1:0] d, input logic clr = 1'b0);
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
`ifdef STACK_ERR_FLAGS_EN
    err_clear = clr;
`endif
    @(posedge clk);
    m_update(p, q, d, clr);
    #1;
    push = 1'b0;
    pop  = 1'b0;
`ifdef STACK_ERR_FLAGS_EN
    err_clear = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow_err, underflow_err); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    total++; if (data_out !== 8'h33) begin bad++; $display("FAIL basic_top got=%h exp=33", data_out); end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'h22) begin bad++; $display("FAIL basic_pop1 got=%h exp=22", data_out); end
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL basic_pop2 got=%h exp=11", data_out); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_pop_count got=%0d exp=1", count); end
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("FAIL basic_pop_last got=%h/%b exp=00/1", data_out, empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, W'(i));
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
    step(1, 0, 8'h05);
    total++; if (data_out !== 8'h04) begin bad++; $display("FAIL ovf_top got=%h exp=04", data_out); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_err); end
    step(0, 0, 8'h00, 1'b1);
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow_err); end
    step(1, 0, 8'h06, 1'b1);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_clear_vs_set got=%b exp=1", overflow_err); end
`endif
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'h03) begin bad++; $display("FAIL ovf_pop_from_full got=%h exp=03", data_out); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 1, 8'h00);
    total++; if (empty !== 1'b1 || data_out !== 8'h00) begin
      bad++; $display("FAIL unf_state got=%b/%h exp=1/00", empty, data_out); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", underflow_err); end
`endif
    step(1, 0, 8'h7F);
    total++; if (data_out !== 8'h7F || count !== 3'd1) begin
      bad++; $display("FAIL unf_push got=%h/%0d exp=7f/1", data_out, count); end
  endtask

  task automatic test_replace();
    do_reset();
    step(1, 0, 8'hA0);
    step(1, 0, 8'hB0);
    step(1, 1, 8'hC0);
    total++; if (count !== 3'd2 || data_out !== 8'hC0) begin
      bad++; $display("FAIL repl_state got=%0d/%h exp=2/c0", count, data_out); end
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'hA0) begin bad++; $display("FAIL repl_pop got=%h exp=a0", data_out); end
    step(1, 0, 8'hB1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);
    step(1, 1, 8'hEE);
    total++; if (count !== 3'd4 || full !== 1'b1 || data_out !== 8'hEE) begin
      bad++; $display("FAIL repl_full got=%0d/%b/%h exp=4/1/ee", count, full, data_out); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL repl_full_noovf got=%b exp=0", overflow_err); end
`endif
    step(0, 1, 8'h00);
    total++; if (data_out !== 8'hB2) begin bad++; $display("FAIL repl_full_pop got=%h exp=b2", data_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 1, 8'h00);
    step(1, 0, 8'h31);
    step(1, 0, 8'h32);
    step(1, 0, 8'h33);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (data_out !== 8'h00 || count !== 3'd0 || full !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL async_reset got=%h/%0d/%b/%b exp=00/0/0/1", data_out, count, full, empty); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
      bad++; $display("FAIL async_reset_flags got=%b%b exp=00", overflow_err, underflow_err); end
`endif
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 8'h55);
    total++; if (data_out !== 8'h55 || count !== 3'd1) begin
      bad++; $display("FAIL async_after got=%h/%0d exp=55/1", data_out, count); end
  endtask

  task automatic test_replace_empty();
    do_reset();
    step(1, 1, 8'h9A);
    total++; if (count !== 3'd1 || data_out !== 8'h9A) begin
      bad++; $display("FAIL repl_empty got=%0d/%h exp=1/9a", count, data_out); end
`ifdef STACK_ERR_FLAGS_EN
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL repl_empty_unf got=%b exp=1", underflow_err); end
`endif
  endtask

  task automatic test_random();
    logic p, q, clr;
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p   = ($urandom_range(0, 99) < 55);
      q   = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 15) == 0);
      d   = W'($urandom);
      step(p, q, d, clr);
      total++; if (data_out !== m_top()) begin
        bad++; $display("FAIL rand_top i=%0d got=%h exp=%h", i, data_out, m_top()); end
      total++; if (count !== CW'(mq.size())) begin
        bad++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
      total++; if (full !== (mq.size() == D) || empty !== (mq.size() == 0)) begin
        bad++; $display("FAIL rand_flags i=%0d got=%b%b exp=%b%b", i, full, empty, mq.size() == D, mq.size() == 0); end
`ifdef STACK_ERR_FLAGS_EN
      total++; if (overflow_err !== m_ovf || underflow_err !== m_unf) begin
        bad++; $display("FAIL rand_err i=%0d got=%b%b exp=%b%b", i, overflow_err, underflow_err, m_ovf, m_unf); end
`endif
    end
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
`ifdef STACK_ERR_FLAGS_EN
    err_clear = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_replace();
    test_async_reset();
    test_replace_empty();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
